mem_line_xfer: RTL and testbench

//  Line-transfer sequencer between the direct-mapped cache FSM and the four-banked main memory.

---
 rtl/mem_line_xfer_if.sv | 25 ++
 rtl/mem_line_xfer.sv | 147 ++++++++++++++
 tb/tb_mem_line_xfer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_line_xfer_if.sv
// Memory-side bus of the line-transfer sequencer: word address/data, read/write strobes,
// returned read data and the stall/busy/error status coming back from the banked memory.
interface mem_line_xfer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data_in;
    logic              m_rd;
    logic              m_wr;
    logic [DATA_W-1:0] m_data_out;
    logic              m_stall;
    logic [3:0]        m_busy;
    logic              m_err;

    modport master (
        output m_addr, m_data_in, m_rd, m_wr,
        input  m_data_out, m_stall, m_busy, m_err
    );

    modport slave (
        input  m_addr, m_data_in, m_rd, m_wr,
        output m_data_out, m_stall, m_busy, m_err
    );
endinterface

// File: rtl/mem_line_xfer.sv
// Line-transfer sequencer: one fill/writeback request becomes four per-bank word accesses.
// Build option XFER_CRITICAL_FIRST_EN: fills start at the requested word and wrap.
module mem_line_xfer #(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wb,
    input  logic [ADDR_W-1:0] req_addr,
    output logic [1:0]        wb_idx,
    input  logic [DATA_W-1:0] wb_data,
    output logic              fill_valid,
    output logic [1:0]        fill_idx,
    output logic [DATA_W-1:0] fill_data,
    output logic              done,
    output logic              err,
    mem_line_xfer_if.master   mem
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    localparam logic [RD_LAT-1:0] TAIL_BIT = RD_LAT'(1) << (RD_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-4:0] line_q, line_d;
    logic              wb_q, wb_d;
    logic [1:0]        k_q, k_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [1:0]        pipe_idx_q [RD_LAT];
    logic [1:0]        pipe_idx_d [RD_LAT];

    logic              rd_fire, wr_fire, issue_ok, drain_last;
    logic [1:0]        start_idx;
    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_data_in_o;
    logic [2:0]        unused_addr_bits;

    assign unused_addr_bits = req_addr[2:0];

`ifdef XFER_CRITICAL_FIRST_EN
    assign start_idx = req_wb ? 2'd0 : req_addr[2:1];
`else
    assign start_idx = 2'd0;
`endif

    assign issue_ok = !mem.m_stall && !mem.m_busy[k_q];
    // Only the tail entry left means the pipe is empty next cycle, so DONE follows the last fill.
    assign drain_last = ((pipe_vld_q & ~TAIL_BIT) == '0);

    assign pipe_vld_d[0] = rd_fire;
    assign pipe_idx_d[0] = k_q;
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
        assign pipe_vld_d[gi] = pipe_vld_q[gi-1];
        assign pipe_idx_d[gi] = pipe_idx_q[gi-1];
    end

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        wb_d        = wb_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        req_ready   = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        rd_fire     = 1'b0;
        wr_fire     = 1'b0;
        m_addr_o    = '0;
        m_data_in_o = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    line_d  = req_addr[ADDR_W-1:3];
                    wb_d    = req_wb;
                    k_d     = start_idx;
                    cnt_d   = 2'd0;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                err_d       = err_q | mem.m_err;
                m_addr_o    = {line_q, k_q, 1'b0};
                m_data_in_o = wb_data;
                if (issue_ok) begin
                    rd_fire = !wb_q;
                    wr_fire = wb_q;
                    k_d     = k_q + 2'd1;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = wb_q ? S_DONE : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                err_d = err_q | mem.m_err;
                if (drain_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                err     = err_q | mem.m_err;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            line_q     <= '0;
            wb_q       <= 1'b0;
            k_q        <= 2'd0;
            cnt_q      <= 2'd0;
            err_q      <= 1'b0;
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_idx_q[i] <= 2'd0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            wb_q       <= wb_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            pipe_vld_q <= pipe_vld_d;
            for (int i = 0; i < RD_LAT; i++) pipe_idx_q[i] <= pipe_idx_d[i];
        end
    end

    assign wb_idx        = k_q;
    assign fill_valid    = pipe_vld_q[RD_LAT-1];
    assign fill_idx      = pipe_idx_q[RD_LAT-1];
    assign fill_data     = mem.m_data_out;
    assign mem.m_addr    = m_addr_o;
    assign mem.m_data_in = m_data_in_o;
    assign mem.m_rd      = rd_fire;
    assign mem.m_wr      = wr_fire;
endmodule

// File: tb/tb_mem_line_xfer.sv
// Randomized bench for mem_line_xfer: a transaction-level model predicts every strobe,
// fill word and done/err pulse from the line-transfer rules; one line per transfer.
module tb_mem_line_xfer;
    localparam int RD_LAT = 2;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              req_valid, req_ready, req_wb;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        wb_idx, fill_idx;
    logic [DATA_W-1:0] wb_data, fill_data, wb_base;
    logic              fill_valid, done, err;

    always #5 clk = ~clk;

    mem_line_xfer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

    mem_line_xfer #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb), .req_addr(req_addr),
        .wb_idx(wb_idx), .wb_data(wb_data),
        .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
        .done(done), .err(err), .mem(mif)
    );

    // Cache side: the writeback word for index i is wb_base + i.
    assign wb_data = wb_base + {14'd0, wb_idx};

    typedef struct {
        int          due;
        logic [1:0]  idx;
        logic [15:0] data;
    } rd_t;

    int   n_checks = 0, n_pass = 0, n_xfer = 0, cyc = 0;
    bit   in_xfer = 0, x_wb = 0, err_acc = 0;
    logic [12:0] x_line;
    logic [1:0]  order [4];
    int   issued = 0, fills = 0, done_due = -1;
    rd_t  pend [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic drive_inputs(input bit allow_req);
        mif.m_stall = ($urandom_range(0, 3) == 0);
        mif.m_busy  = 4'($urandom) & 4'($urandom);
        mif.m_err   = ($urandom_range(0, 15) == 0);
        req_valid   = allow_req && ($urandom_range(0, 1) == 1);
        req_wb      = 1'($urandom);
        req_addr    = 16'($urandom);
        wb_base     = 16'($urandom);
        if (pend.size() > 0 && pend[0].due == cyc) mif.m_data_out = pend[0].data;
        else mif.m_data_out = 16'($urandom);
    endtask

    // Compare the current cycle against the model, then advance the model to the next cycle.
    task automatic step();
        logic [1:0]  k;
        logic [15:0] a;
        logic [1:0]  start;
        bit          exp_fire, exp_fv, is_done;
        chk("req_ready", 32'(req_ready), 32'(!in_xfer));
        if (!in_xfer) begin
            chk("rd_idle", 32'(mif.m_rd), 32'd0);
            chk("wr_idle", 32'(mif.m_wr), 32'd0);
            chk("fill_idle", 32'(fill_valid), 32'd0);
            chk("done_idle", 32'(done), 32'd0);
            chk("err_idle", 32'(err), 32'd0);
            if (req_valid) begin
`ifdef XFER_CRITICAL_FIRST_EN
                start = req_wb ? 2'd0 : req_addr[2:1];
`else
                start = 2'd0;
`endif
                for (int i = 0; i < 4; i++) order[i] = start + 2'(i);
                in_xfer  = 1;
                x_wb     = req_wb;
                x_line   = req_addr[15:3];
                issued   = 0;
                fills    = 0;
                err_acc  = 0;
                done_due = -1;
            end
            return;
        end
        exp_fire = 0;
        k = 2'd0;
        a = 16'd0;
        if (issued < 4) begin
            k = order[issued];
            a = {x_line, k, 1'b0};
            chk("wb_idx", 32'(wb_idx), 32'(k));
            chk("m_addr", 32'(mif.m_addr), 32'(a));
            exp_fire = !mif.m_stall && !mif.m_busy[k];
            chk("m_rd", 32'(mif.m_rd), 32'(exp_fire && !x_wb));
            chk("m_wr", 32'(mif.m_wr), 32'(exp_fire && x_wb));
            if (exp_fire && x_wb) chk("m_data_in", 32'(mif.m_data_in), 32'(wb_base + 16'(k)));
        end else begin
            chk("rd_after4", 32'(mif.m_rd), 32'd0);
            chk("wr_after4", 32'(mif.m_wr), 32'd0);
        end
        exp_fv = pend.size() > 0 && pend[0].due == cyc;
        chk("fill_valid", 32'(fill_valid), 32'(exp_fv));
        if (exp_fv) begin
            chk("fill_idx", 32'(fill_idx), 32'(pend[0].idx));
            chk("fill_data", 32'(fill_data), 32'(pend[0].data));
            void'(pend.pop_front());
            fills++;
            if (fills == 4) done_due = cyc + 1;
        end
        is_done = (cyc == done_due);
        chk("done", 32'(done), 32'(is_done));
        if (is_done) begin
            chk("err", 32'(err), 32'(err_acc || mif.m_err));
            n_xfer++;
            $display("xfer %0d: %s line=%h err=%0d done at cycle %0d",
                     n_xfer, x_wb ? "writeback" : "fill", x_line, err_acc || mif.m_err, cyc);
            in_xfer = 0;
        end else begin
            err_acc = err_acc || mif.m_err;
        end
        if (exp_fire) begin
            if (!x_wb) pend.push_back('{cyc + RD_LAT, k, mem_word(a)});
            issued++;
            if (issued == 4 && x_wb) done_due = cyc + 1;
        end
    endtask

    task automatic one_cycle();
        @(posedge clk);
        cyc++;
        #1 drive_inputs(1);
        @(negedge clk);
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rd"}, 32'(mif.m_rd), 32'd0);
        chk({tag, "_wr"}, 32'(mif.m_wr), 32'd0);
        chk({tag, "_fill"}, 32'(fill_valid), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_addr"}, 32'(mif.m_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mif.m_data_in), 32'd0);
    endtask

    task automatic reset_mid();
        int budget = 0;
        while (!(in_xfer && issued >= 1 && issued < 4) && budget < 200) begin
            one_cycle();
            budget++;
        end
        chk("rst_wait_timeout", 32'(budget < 200), 32'd1);
        @(posedge clk);
        cyc++;
        #1 rst_n = 1'b0;
        drive_inputs(0);
        pend.delete();
        in_xfer = 0;
        #1 check_reset_outputs("rst_mid");
        repeat (3) begin
            @(posedge clk);
            cyc++;
            #1 drive_inputs(0);
            @(negedge clk);
            chk("rst_hold_fill", 32'(fill_valid), 32'd0);
            chk("rst_hold_done", 32'(done), 32'd0);
            chk("rst_hold_rd", 32'(mif.m_rd), 32'd0);
        end
        @(posedge clk);
        cyc++;
        #1 rst_n = 1'b1;
        drive_inputs(1);
        @(negedge clk);
        step();
    endtask

    initial begin
        req_valid = 0; req_wb = 0; req_addr = '0; wb_base = '0;
        mif.m_stall = 0; mif.m_busy = '0; mif.m_err = 0; mif.m_data_out = '0;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(posedge clk);
        cyc++;
        #1 rst_n = 1'b1;
        drive_inputs(1);
        @(negedge clk);
        step();
        repeat (1500) one_cycle();
        reset_mid();
        repeat (800) one_cycle();
        reset_mid();
        repeat (800) one_cycle();
        chk("xfer_count", 32'(n_xfer > 50), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
